// File: rtl/spi_master.sv
// Mode-0 SPI master: sends a 16-bit frame {addr, rw, data} MSB first and,
// for reads, returns the slave's data byte on rdata when done pulses.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam logic [7:0] H_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic [7:0]  capture;
  logic        rw_reg;
  logic        phase_end;

  assign phase_end = (cnt == H_LAST);

  // shift_reg holds the bits still to be driven, so mosi_pin only ever
  // advances on an sclk falling transition and ends at 0 after bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      capture   <= '0;
      rw_reg    <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sclk_pin  <= 1'b0;
      cs_pin    <= 1'b1;
      mosi_pin  <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= (state == IDLE || phase_end) ? 8'd0 : cnt + 8'd1;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SETUP;
            busy      <= 1'b1;
            cs_pin    <= 1'b0;
            mosi_pin  <= addr[6];
            shift_reg <= {addr[5:0], rw, (rw ? 8'h00 : wdata), 1'b0};
            rw_reg    <= rw;
            bit_cnt   <= '0;
            capture   <= '0;
          end
        end
        SETUP: begin
          if (phase_end) begin
            state    <= SHIFT;
            sclk_pin <= 1'b1;
          end
        end
        SHIFT: begin
          if (phase_end) begin
            if (sclk_pin) begin
              sclk_pin  <= 1'b0;
              mosi_pin  <= shift_reg[15];
              shift_reg <= {shift_reg[14:0], 1'b0};
              if (rw_reg && bit_cnt[3]) begin
                capture <= {capture[6:0], miso_pin};
              end
            end else if (bit_cnt == 4'd15) begin
              state <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              sclk_pin <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            state  <= GAP;
            cs_pin <= 1'b1;
          end
        end
        GAP: begin
          if (phase_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (rw_reg) begin
              rdata <= capture;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  transaction request, sampled each clk.
REQ-005 rw  input  1  1 = read, 0 = write; captured with start.
REQ-006 addr  input  7  memory address; captured with start.
REQ-007 wdata  input  8  write data; captured with start.
REQ-008 rdata  output  8  last read result.
REQ-009 busy  output  1  transaction in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 sclk_pin  output  1  SPI clock, idle low (mode 0).
REQ-012 cs_pin  output  1  SPI chip select, active low.
REQ-013 mosi_pin  output  1  master-out serial data.
REQ-014 miso_pin  input  1  slave-out serial data.

Function
REQ-015 Frame is 16 bits, MSB first: byte 0 = {addr[6:0], rw}; byte 1 = wdata for write, 8'h00 on mosi_pin for read.
REQ-016 FSM states are IDLE, SETUP, SHIFT, HOLD and GAP; let H = CLK_DIV.
REQ-017 IDLE: cs_pin=1, sclk_pin=0, busy=0; start=1 captures rw/addr/wdata into a 16-bit shift register and enters SETUP on the same edge.
REQ-018 SETUP: cs_pin=0, sclk_pin=0, mosi_pin=frame bit 15, for H cycles, then SHIFT.
REQ-019 SHIFT: 16 bit periods of 2H cycles each (sclk_pin high H cycles, then low H cycles); mosi_pin changes only on the sclk falling transition, to the next bit.
REQ-020 Read frames: miso_pin is sampled in the last clk cycle of each sclk-high phase for bits 7..0 (data byte) and shifted MSB first into a capture register; miso_pin is ignored for all other bits and for write frames.
REQ-021 After the 16th low phase the FSM enters HOLD: cs_pin=0, sclk_pin=0 for H cycles, then GAP.
REQ-022 GAP: cs_pin=1, sclk_pin=0 for H cycles, then IDLE with done=1 for exactly one cycle.
REQ-023 busy=1 from the cycle after start acceptance through the last GAP cycle: exactly 35H cycles.
REQ-024 rdata loads from the capture register in the same cycle done rises, for read frames only; write frames leave rdata unchanged.
REQ-025 start while busy=1 is ignored and is not queued.
REQ-026 start=1 in the done cycle (IDLE) is accepted, so back-to-back frames are separated by at least H cycles of cs_pin=1.
REQ-027 No SCLK edge occurs while cs_pin=1; cs_pin never toggles while sclk_pin=1.
REQ-028 Bit and half-period counters are sized for 16 bits and 255 cycles; no wrap-around occurs within legal parameter values.

Reset
REQ-029 reset=1 forces, on the next edge: state IDLE, cs_pin=1, sclk_pin=0, mosi_pin=0, busy=0, done=0, rdata=8'h00, and shift, capture and counters all cleared.
REQ-030 Reset mid-transaction aborts the frame immediately, with no done pulse and no rdata update; reset has priority over start.
REQ-031 The first start after reset deasserts is accepted normally.

Verification
REQ-032 CLK_DIV=4; write addr=7'h15, wdata=8'hA5 -> mosi_pin bits 0x2A then 0xA5; 16 sclk rising edges; busy high 140 cycles; done one cycle; rdata unchanged.
REQ-033 Read addr=7'h15 against a behavioural slave that drives 8'h3C after each sclk falling edge -> mosi_pin carries 0x2B then 0x00; rdata=8'h3C in the done cycle.
REQ-034 start pulsed at cycles 10 and 50 of a busy transaction -> no effect; exactly one done.
REQ-035 Reset asserted during bit 5 of SHIFT -> next cycle cs_pin=1, sclk_pin=0, busy=0; no done; rdata=8'h00.
REQ-036 start held high continuously with CLK_DIV=2 -> successive frames each take 70 busy cycles; cs_pin high at least 2 cycles between frames.
REQ-037 A checker asserts REQ-027 and the exact 2H SCLK period throughout all scenarios.
